// File: rtl/line_tx_pkg.sv
// line_tx_pkg: shared line TX constants, header byte offsets and streamer FSM states
package line_tx_pkg;
  localparam int LINE_BYTES = 1440;
  localparam int HDR_BYTES = 4;
  localparam int LINES_PER_FRAME = 40;
  localparam logic [1:0] HDR_FRAME = 2'd0;
  localparam logic [1:0] HDR_LINE = 2'd1;
  localparam logic [1:0] HDR_LEN_HI = 2'd2;
  localparam logic [1:0] HDR_LEN_LO = 2'(HDR_BYTES - 1);
  typedef enum logic [1:0] {IDLE, HDR, BODY, TRL} state_t;
endpackage

// File: rtl/stream_skid2.sv
// stream_skid2: 2-entry byte FIFO with fall-through head and occupancy output
// Ports: clk, rst_n (sync, active-low); in_valid/in_data/in_ready write side;
// out_valid/out_data/out_ready read side; occ = stored entries (0..2).
// When empty, an incoming byte is presented on the head in the same cycle,
// so a 1-cycle-latency source can sustain one beat per cycle.
module stream_skid2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [1:0] occ
);
  logic [7:0] mem [2];
  logic rp, wp, wr, rd;
  assign in_ready = occ != 2'd2;
  assign out_valid = occ != 2'd0 || in_valid;
  assign out_data = occ != 2'd0 ? mem[rp] : in_data;
  assign wr = in_valid && in_ready && !(occ == 2'd0 && out_ready);
  assign rd = out_ready && occ != 2'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= 2'd0;
      rp <= 1'b0;
      wp <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= in_data;
        wp <= ~wp;
      end
      if (rd) rp <= ~rp;
      occ <= occ + {1'b0, wr} - {1'b0, rd};
    end
  end
endmodule

// File: rtl/line_payload_streamer.sv
// line_payload_streamer: streams one line buffer line as header + body (+ checksum) payload
// Ports: clk, rst_n (sync, active-low); start/frame_id/line_no request a line;
// busy; rd_addr/rd_data line buffer read port (1-cycle latency);
// tx_data/tx_valid/tx_ready/tx_last payload stream; done pulses after the last beat.
// Build option: define LINE_PAYLOAD_CSUM_EN to append a 16-bit body byte sum (MSB first).
module line_payload_streamer #(
  parameter int LINE_BYTES = line_tx_pkg::LINE_BYTES,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        frame_id,
  input  logic [7:0]        line_no,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              done
);
  import line_tx_pkg::*;
  localparam int CW = $clog2(LINE_BYTES + 1);
  localparam logic [15:0] LEN = 16'(LINE_BYTES);
  state_t state, state_d;
  logic [7:0] fid, lno, f_data;
  logic [1:0] hidx, occ;
  logic [CW-1:0] bidx, pidx;
  logic inflight, issue, f_valid, f_ready, f_in_ready, last_body;
`ifdef LINE_PAYLOAD_CSUM_EN
  logic [15:0] csum;
  logic tidx;
`endif
  assign busy = state != IDLE;
  assign last_body = pidx == CW'(LINE_BYTES - 1);
  // occupancy plus the read still in flight bounds what can land in the skid FIFO
  assign issue = (state == HDR || state == BODY) && bidx < CW'(LINE_BYTES) && f_in_ready
                 && (occ + {1'b0, inflight}) < 2'd2;
  stream_skid2 u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(inflight),
    .in_data(rd_data),
    .in_ready(f_in_ready),
    .out_valid(f_valid),
    .out_data(f_data),
    .out_ready(f_ready),
    .occ(occ)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fid <= 8'd0;
      lno <= 8'd0;
      hidx <= 2'd0;
      bidx <= '0;
      pidx <= '0;
      inflight <= 1'b0;
      rd_addr <= '0;
      done <= 1'b0;
`ifdef LINE_PAYLOAD_CSUM_EN
      csum <= 16'd0;
      tidx <= 1'b0;
`endif
    end else begin
      state <= state_d;
      done <= busy && state_d == IDLE;
      inflight <= issue;
      if (state == IDLE && start) begin
        fid <= frame_id;
        lno <= line_no;
        hidx <= 2'd0;
        bidx <= '0;
        pidx <= '0;
        rd_addr <= '0;
`ifdef LINE_PAYLOAD_CSUM_EN
        csum <= 16'd0;
        tidx <= 1'b0;
`endif
      end else begin
        if (issue) bidx <= bidx + 1'b1;
        if (issue && bidx != CW'(LINE_BYTES - 1)) rd_addr <= rd_addr + 1'b1;
        if (state == HDR && tx_ready) hidx <= hidx + 1'b1;
        if (state == BODY && f_valid && tx_ready) pidx <= pidx + 1'b1;
`ifdef LINE_PAYLOAD_CSUM_EN
        if (state == BODY && f_valid && tx_ready) csum <= csum + {8'd0, f_data};
        if (state == TRL && tx_ready) tidx <= 1'b1;
`endif
      end
    end
  end
  always_comb begin
    state_d = state;
    tx_valid = 1'b0;
    tx_data = 8'd0;
    tx_last = 1'b0;
    f_ready = 1'b0;
    case (state)
      IDLE: state_d = start ? HDR : IDLE;
      HDR: begin
        tx_valid = 1'b1;
        tx_data = hidx == HDR_FRAME ? fid : hidx == HDR_LINE ? lno : hidx == HDR_LEN_HI ? LEN[15:8] : LEN[7:0];
        state_d = tx_ready && hidx == HDR_LEN_LO ? BODY : HDR;
      end
      BODY: begin
        tx_valid = f_valid;
        tx_data = f_data;
        f_ready = tx_ready;
`ifdef LINE_PAYLOAD_CSUM_EN
        state_d = f_valid && tx_ready && last_body ? TRL : BODY;
`else
        tx_last = f_valid && last_body;
        state_d = f_valid && tx_ready && last_body ? IDLE : BODY;
`endif
      end
      default: begin
`ifdef LINE_PAYLOAD_CSUM_EN
        tx_valid = 1'b1;
        tx_data = tidx ? csum[7:0] : csum[15:8];
        tx_last = tidx;
        state_d = tx_ready && tidx ? IDLE : TRL;
`else
        state_d = IDLE;
`endif
      end
    endcase
  end
endmodule

// File: tb/tb_line_payload_streamer.sv
// tb_line_payload_streamer: randomized self-checking bench against a payload-level reference model
module tb_line_payload_streamer;
  localparam int LB = 1440;
`ifdef LINE_PAYLOAD_CSUM_EN
  localparam int NB = LB + 6;
`else
  localparam int NB = LB + 4;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic [7:0] frame_id = 8'd0, line_no = 8'd0, rd_data, tx_data;
  logic busy, tx_valid, tx_last, done;
  logic [12:0] rd_addr;
  logic [7:0] lb [LB];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int total = 0, bad = 0;
  int last_cnt, last_pos, done_cnt, done_cyc, first_cyc, stab_err, busy_err, ra_max, ra_moved, fd;
  bit timeout;

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= rd_addr < 13'(LB) ? lb[rd_addr] : 8'h00;

  line_payload_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_id(frame_id), .line_no(line_no),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .done(done)
  );

  task automatic build_exp(input logic [7:0] fid, input logic [7:0] lno);
    exp_q = '{fid, lno, 8'h05, 8'hA0};
    for (int i = 0; i < LB; i++) exp_q.push_back(lb[i]);
`ifdef LINE_PAYLOAD_CSUM_EN
    begin
      logic [15:0] s;
      s = 16'd0;
      for (int i = 0; i < LB; i++) s = s + 16'(lb[i]);
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
    end
`endif
  endtask

  function automatic int first_diff();
    if (got.size() != exp_q.size()) return -2;
    foreach (got[i]) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // mode 0: ready high; 1: ready random; 2: ready low 20 cycles on first body beat
  task automatic drive_line(input logic [7:0] fid, input logic [7:0] lno, input int mode, input int inj_at, input int rst_at);
    bit stall_prev = 0;
    logic [7:0] pd = 8'd0;
    logic pl = 1'b0;
    int stall_n = 0;
    logic [12:0] ra0 = '0;
    got.delete();
    last_cnt = 0; last_pos = -1; done_cnt = 0; done_cyc = -1; first_cyc = -1;
    stab_err = 0; busy_err = 0; ra_max = 0; ra_moved = 0; timeout = 1;
    build_exp(fid, lno);
    @(negedge clk);
    start = 1'b1; frame_id = fid; line_no = lno; tx_ready = 1'b1;
    for (int c = 1; c < 10000; c++) begin
      @(negedge clk);
      start = inj_at >= 0 && got.size() == 4 + inj_at;
      frame_id = 8'($urandom); line_no = 8'($urandom);
      tx_ready = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? !(got.size() == 4 && stall_n < 20) : 1'b1;
      if (mode == 2 && !tx_ready) stall_n++;
      if (rst_at >= 0 && got.size() == 4 + rst_at) begin
        rst_n = 1'b0; timeout = 0;
        break;
      end
      #1;
      if (stall_prev && (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl)) stab_err++;
      if (tx_valid === 1'b1 && first_cyc < 0) first_cyc = c;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (done_cnt == 0)) busy_err++;
      if (mode == 2 && !tx_ready && stall_n == 1) begin ra0 = rd_addr; ra_max = int'(rd_addr); end
      if (mode == 2 && !tx_ready && stall_n > 1) begin
        if (rd_addr !== ra0) ra_moved = 1;
        if (int'(rd_addr) > ra_max) ra_max = int'(rd_addr);
      end
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (tx_last) begin last_cnt++; last_pos = got.size(); end
      end
      stall_prev = tx_valid && !tx_ready; pd = tx_data; pl = tx_last;
      if (done_cnt > 0 && c >= done_cyc + 4) begin timeout = 0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({busy, tx_valid, tx_last, done, tx_data, rd_addr} !== 25'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {busy, tx_valid, tx_last, done, tx_data, rd_addr});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < LB; i++) lb[i] = 8'h19;
    drive_line(8'h03, 8'h07, 0, -1, -1);
    total++; if (timeout) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL basic_payload first_diff=%0d size=%0d want=-1/%0d", fd, got.size(), NB); end
    total++; if (got.size() < 4 || {got[0], got[1], got[2], got[3]} !== 32'h030705A0) begin bad++; $display("FAIL basic_header got size=%0d want 030705A0", got.size()); end
`ifdef LINE_PAYLOAD_CSUM_EN
    total++; if (got.size() != NB || {got[NB-2], got[NB-1]} !== 16'h8CA0) begin bad++; $display("FAIL basic_csum size=%0d want trailer 8CA0", got.size()); end
`endif
    total++; if (first_cyc != 1) begin bad++; $display("FAIL basic_first_valid got=%0d want=1", first_cyc); end
    total++; if (last_cnt != 1 || last_pos != NB) begin bad++; $display("FAIL basic_last got cnt=%0d pos=%0d want 1/%0d", last_cnt, last_pos, NB); end
    total++; if (done_cyc != NB + 1 || done_cnt != 1) begin bad++; $display("FAIL basic_done got cyc=%0d cnt=%0d want %0d/1", done_cyc, done_cnt, NB + 1); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL basic_busy got=%0d want=0", busy_err); end
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < LB; i++) lb[i] = 8'((1 + 11 * i) % 255);
    drive_line(8'($urandom), 8'($urandom_range(0, 39)), 1, -1, -1);
    total++; if (timeout) begin bad++; $display("FAIL rand_timeout got=1 want=0"); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL rand_payload first_diff=%0d size=%0d want=-1/%0d", fd, got.size(), NB); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL rand_stable got=%0d want=0", stab_err); end
    total++; if (last_cnt != 1 || last_pos != NB) begin bad++; $display("FAIL rand_last got cnt=%0d pos=%0d want 1/%0d", last_cnt, last_pos, NB); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rand_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < LB; i++) lb[i] = 8'($urandom);
    drive_line(8'($urandom), 8'($urandom_range(0, 39)), 2, -1, -1);
    total++; if (timeout) begin bad++; $display("FAIL stall_timeout got=1 want=0"); end
    total++; if (ra_moved != 0 || ra_max > 2) begin bad++; $display("FAIL stall_rd_addr got moved=%0d max=%0d want 0/<=2", ra_moved, ra_max); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stab_err); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL stall_payload first_diff=%0d size=%0d want=-1/%0d", fd, got.size(), NB); end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < LB; i++) lb[i] = 8'($urandom);
    drive_line(8'h55, 8'h12, 0, 100, -1);
    total++; if (done_cnt != 1 || done_cyc != NB + 1) begin bad++; $display("FAIL ign_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, NB + 1); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL ign_busy got=%0d want=0", busy_err); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL ign_payload first_diff=%0d size=%0d want=-1/%0d", fd, got.size(), NB); end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    for (int i = 0; i < LB; i++) lb[i] = 8'($urandom);
    drive_line(8'hA1, 8'h27, 0, -1, 700);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({busy, tx_valid, tx_last, done, tx_data, rd_addr} !== 25'd0) begin
      bad++; $display("FAIL midrst_outputs got=%h want=0", {busy, tx_valid, tx_last, done, tx_data, rd_addr});
    end
    repeat (5) begin
      @(negedge clk); #1;
      if (done === 1'b1 || tx_valid === 1'b1) dn++;
    end
    total++; if (dn != 0) begin bad++; $display("FAIL midrst_quiet got=%0d want=0", dn); end
    drive_line(8'h0B, 8'h21, 0, -1, -1);
    fd = first_diff();
    total++; if (timeout || fd != -1) begin bad++; $display("FAIL midrst_payload timeout=%0d first_diff=%0d want 0/-1", timeout, fd); end
    total++; if (last_pos != NB || done_cyc != NB + 1) begin bad++; $display("FAIL midrst_last got pos=%0d done=%0d want %0d/%0d", last_pos, done_cyc, NB, NB + 1); end
  endtask

  initial begin
    for (int i = 0; i < LB; i++) lb[i] = 8'h00;
    test_reset();
    test_basic();
    test_random_ready();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_payload_streamer.md
# line_payload_streamer

Streams one video line out of the 1440-byte TX line buffer as an Ethernet payload byte stream. Each payload is a 4-byte header (frame id, line number, length) followed by the line bytes. The block sits between the line buffer's read port (1-cycle registered read) and the TX packet builder/MAC. It absorbs downstream back-pressure without losing RAM read data.

## Interface
- `LINE_BYTES`, 1440: body bytes per line (57600-byte frame / 40 lines).
- `ADDR_W`, 13: line buffer address width.
- `clk`  in  1  single clock; line buffer read port and TX stream share it.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse: line buffer holds a complete line.
- `frame_id`  in  8  frame number; sampled when `start` is accepted.
- `line_no`  in  8  line number 0..39; sampled when `start` is accepted.
- `busy`  out  1  high from accepted `start` until the final beat handshake.
- `rd_addr`  out  ADDR_W  line buffer read address.
- `rd_data`  in  8  line buffer read data, valid one cycle after `rd_addr`.
- `tx_data`  out  8  payload byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  consumer accepts the beat when `tx_valid && tx_ready`.
- `tx_last`  out  1  marks the final payload beat.
- `done`  out  1  one-cycle pulse after the final beat handshake.

## Operation
- FSM states: IDLE, HDR, BODY, TRL (checksum build only).
- IDLE:
  - `start` is accepted only in IDLE.
  - On acceptance, latch `frame_id`/`line_no`, clear the header index, body read index and checksum, then go to HDR.
  - `start` while `busy` is ignored; it is neither queued nor counted.
- HDR:
  - Emit bytes `frame_id`, `line_no`, `LINE_BYTES[15:8]`, `LINE_BYTES[7:0]` (0x05, 0xA0), in that order, one per handshake.
  - Body prefetch starts on HDR entry so the first body byte is ready when the header ends.
  - Go to BODY after the 4th header handshake.
- BODY:
  - Read addresses 0..`LINE_BYTES`-1 are issued in order.
  - Read data lands in a 2-entry skid FIFO. A read is issued only when (FIFO occupancy + reads in flight) < 2, so no returned byte is ever dropped.
  - Beats are emitted from the FIFO head.
  - When the body index reaches `LINE_BYTES`, stop issuing reads; `rd_addr` holds its last value.
  - After the final body handshake, go to IDLE (or TRL when the checksum is compiled in).
- `tx_last` is high only on the final beat of the payload.
- `done` pulses in the cycle after that beat's handshake; `busy` falls in the same cycle.
- Stream rule: while `tx_valid && !tx_ready`, `tx_data`, `tx_valid` and `tx_last` hold stable. `tx_valid` never drops without a handshake.
- Reset mid-line: the FSM returns to IDLE, the skid FIFO and in-flight reads are discarded, and the partial payload is abandoned; there is no `done`.

## Timing
- Reset values: `busy`=0, `rd_addr`=0, `tx_data`=0, `tx_valid`=0, `tx_last`=0, `done`=0.
- `start` in cycle N puts `tx_valid` high in cycle N+1 with `frame_id`.
- With `tx_ready` held high, one beat per cycle, no bubbles: the header-to-body transition is seamless because of the prefetch.
- A payload takes 4+`LINE_BYTES` beats (1444), plus 2 with the checksum.
- A new `start` is accepted in the cycle `done` is high, so back-to-back lines leave a 1-cycle gap.

## Configuration
- `LINE_PAYLOAD_CSUM_EN` defined:
  - Keep a 16-bit modulo-2^16 sum of all body bytes.
  - TRL appends it MSB first, then LSB; `tx_last` moves to the LSB beat.
- Not defined:
  - No TRL state and no accumulator.
  - `tx_last` is on body byte `LINE_BYTES`-1.

## Structure
- Shared package `line_tx_pkg`:
  - `LINE_BYTES`, `HDR_BYTES`=4, `LINES_PER_FRAME`=40.
  - Header byte offsets.
  - FSM state enum.
- Sub-module `stream_skid2`: 2-entry FIFO with occupancy output and valid/ready pass-through. It is reusable by the packet builder.

## Test plan
- Line buffer all 0x19, `frame_id`=0x03, `line_no`=0x07, `tx_ready`=1 -> beats 03 07 05 A0, then 1440×0x19; `tx_last` on beat 1444; `done` one cycle later; total 1445 cycles from `start`.
- `LINE_PAYLOAD_CSUM_EN` with all-0x19 body -> trailer 8C A0 (36000); `tx_last` on beat 1446.
- `tx_ready` toggling pseudo-randomly (50%), body byte[i] = (1+11i)%255 -> in-order body, no loss or duplication; outputs stable during every stall.
- `tx_ready` low for 20 cycles on the first body beat -> at most 2 reads outstanding; `rd_addr` freezes; stream resumes with byte[0].
- `start` pulsed mid-body -> ignored; `busy` stays high; exactly one `done`.
- `rst_n` low for 1 cycle at body byte 700 -> all outputs reset next cycle; a new `start` produces a full correct 1444-beat payload.
